regfile_2w2r: RTL and testbench
===============================

Name: regfile_2w2r

Overview:
- Parametrised successor to the single-write MIPS register file.
- Configurable data width and register count.
- Two synchronous write ports for dual-issue writeback, two asynchronous read ports, optional hardwired-zero register 0, and asynchronous clearing reset.
- Sits between the decode stage (read addresses) and the writeback stage (write ports) of the processor datapath.

Parameters:
- DATA_W, 32, width of every register and data port.
- DEPTH, 32, number of registers; power of two, minimum 2.
- ADDR_W, 5, address width; must equal log2(DEPTH).
- ZERO_REG, 1, 1: register 0 reads as 0 and ignores writes; 0: register 0 is an ordinary register.

Ports:
- clk  input  1  clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs  input  ADDR_W  read address, port 1.
- rt  input  ADDR_W  read address, port 2.
- we0  input  1  write enable, write port 0.
- wa0  input  ADDR_W  write address, port 0.
- wd0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, write port 1.
- wa1  input  ADDR_W  write address, port 1.
- wd1  input  DATA_W  write data, port 1.
- readData1  output  DATA_W  contents at rs.
- readData2  output  DATA_W  contents at rt.
- wr_conflict  output  1  registered flag: previous cycle had both ports writing the same address.

Behaviour:
- Reset:
  - rst_n low clears all DEPTH registers and wr_conflict to 0 immediately, without waiting for a clock edge.
  - readData1 and readData2 therefore read 0 while rst_n is low.
  - Writes presented while rst_n is low are discarded.
  - Deassertion is asynchronous; the first write is accepted on the first rising edge with rst_n high.
- Writes:
  - On the rising edge, if weN=1, reg[waN] <= wdN.
  - Both ports write in the same cycle when addresses differ.
  - Same-address collision (we0=we1=1, wa0==wa1): port 1 wins, port 0 is dropped, and wr_conflict <= 1 for exactly the next cycle. Otherwise wr_conflict <= 0 on every edge.
  - ZERO_REG=1: writes to address 0 have no effect. A collision at address 0 still sets wr_conflict.
- Reads:
  - Combinational, zero latency: readDataX = reg[addr], with stored values only when WRITE_BYPASS_EN is undefined.
  - A value written on edge k is visible on the read ports after edge k.
  - ZERO_REG=1: address 0 always returns 0.
- Boundaries:
  - Address DEPTH-1 is fully writable and readable.
  - Only the low ADDR_W bits are used; no out-of-range addresses exist.
  - We low with any address or data has no effect.
  - X on wd with we low must not corrupt the array.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding, priority as follows:
  - If we1 and wa1==addr (and address is nonzero when ZERO_REG=1), return wd1.
  - Else if we0 and wa0==addr (same zero rule), return wd0.
  - Else return stored value.
  - Applies to both read ports independently.
  - Forwarding is suppressed while rst_n is low; outputs stay 0.
- Undefined: reads return stored contents only, so a same-cycle write is visible only after the edge.

Test Plan:
- Reset clear:
  - Write 9 to r1 and 0xDEADBEEF to r31, then pulse rst_n low mid-cycle.
  - rs=1, rt=31 must read 0 immediately, before any clock edge.
- Dual write:
  - One edge with we0, wa0=1, wd0=9 and we1, wa1=2, wd1=7.
  - rs=1 reads 9, rt=2 reads 7 after the edge; wr_conflict=0.
- Collision:
  - we0, wa0=5, wd0=0x11 and we1, wa1=5, wd1=0x22 on one edge.
  - r5 reads 0x22; wr_conflict=1 for one cycle, then 0.
- Zero register (ZERO_REG=1):
  - we0 wa0=0 wd0=0xFFFFFFFF.
  - rs=0 reads 0 before and after the edge.
  - Repeat with ZERO_REG=0: reads 0xFFFFFFFF after the edge.
- Bypass:
  - Register r3 holds 4. Present we1 wa1=3 wd1=8 with rt=3 in the same cycle.
  - With RF_WRITE_BYPASS_EN defined: readData2=8 before the edge.
  - Without it: readData2=4 before the edge and 8 after.
- Parametrisation:
  - DATA_W=16, DEPTH=8, ADDR_W=3.
  - Write 0xABCD to r7; rs=7 reads 0xABCD.
  - rs=0 reads 0; all other registers read 0.

Source files
------------

// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with optional hardwired-zero register 0.
// Define RF_WRITE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_2w2r #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic              wr_conflict
);

   localparam bit HasZeroReg = (ZERO_REG != 0);

   if (DEPTH < 2 || (1 << ADDR_W) != DEPTH) begin : gBadParams
      $error("regfile_2w2r: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
   end

   logic [DATA_W-1:0] regs [DEPTH];

   // NOTE: the array is flops, not a RAM macro, so clearing every entry on reset is intended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         wr_conflict <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!(HasZeroReg && i == 0)) begin
               // NOTE: non-blocking so every entry samples this edge's inputs, not a neighbour's update.
               if (we1 && wa1 == ADDR_W'(i)) begin
                  regs[i] <= wd1;
               end else if (we0 && wa0 == ADDR_W'(i)) begin
                  regs[i] <= wd0;
               end
            end
         end
         wr_conflict <= we0 && we1 && (wa0 == wa1);
      end
   end

   function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] result;
      logic              writable;
      writable = !(HasZeroReg && addr == '0);
      result   = writable ? regs[addr] : '0;
`ifdef RF_WRITE_BYPASS_EN
      // Port 1 outranks port 0, mirroring the collision rule on the array.
      if (!rst_n) begin
         result = '0;
      end else if (we1 && wa1 == addr && writable) begin
         result = wd1;
      end else if (we0 && wa0 == addr && writable) begin
         result = wd0;
      end
`endif
      return result;
   endfunction

   // NOTE: both outputs are assigned unconditionally, so no latch can be inferred.
   always_comb begin
      readData1 = readPort(rs);
      readData2 = readPort(rt);
   end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: default, ZERO_REG=0 and 16x8 instances.
module tb_regfile_2w2r;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs, rt, wa0, wa1;
   logic        we0, we1;
   logic [31:0] wd0, wd1;
   logic [31:0] readData1A, readData2A, readData1B, readData2B;
   logic        conflictA, conflictB;

   logic [2:0]  rsC, rtC, wa0C, wa1C;
   logic        we0C, we1C;
   logic [15:0] wd0C, wd1C, readData1C, readData2C;
   logic        conflictC;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   regfile_2w2r dutA (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .readData1(readData1A), .readData2(readData2A), .wr_conflict(conflictA)
   );

   regfile_2w2r #(.ZERO_REG(0)) dutB (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .readData1(readData1B), .readData2(readData2B), .wr_conflict(conflictB)
   );

   regfile_2w2r #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dutC (
      .clk(clk), .rst_n(rst_n), .rs(rsC), .rt(rtC),
      .we0(we0C), .wa0(wa0C), .wd0(wd0C), .we1(we1C), .wa1(wa1C), .wd1(wd1C),
      .readData1(readData1C), .readData2(readData2C), .wr_conflict(conflictC)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      we0C = 1'b0; we1C = 1'b0; wa0C = '0; wa1C = '0; wd0C = '0; wd1C = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      rs = 5'd1; rt = 5'd31; rsC = '0; rtC = '0;
      #2;
      nCompared++;
      if (readData1A !== 32'd0 || readData2A !== 32'd0 || conflictA !== 1'b0) begin
         nMismatched++;
         $display("FAIL reset_initial: got %h/%h/%b want 0/0/0", readData1A, readData2A, conflictA);
      end
      #5 rst_n = 1'b1;
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd1;  wd0 = 32'd9;
      we1 = 1'b1; wa1 = 5'd31; wd1 = 32'hDEADBEEF;
      step();
      idle();
      nCompared++;
      if (readData1A !== 32'd9 || readData2A !== 32'hDEADBEEF) begin
         nMismatched++;
         $display("FAIL reset_prewrite: got %h/%h want 00000009/deadbeef", readData1A, readData2A);
      end
      #2 rst_n = 1'b0;
      #1;
      nCompared++;
      if (readData1A !== 32'd0 || readData2A !== 32'd0) begin
         nMismatched++;
         $display("FAIL reset_async_clear: got %h/%h want 0/0", readData1A, readData2A);
      end
      we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1234;
      step();
      we0 = 1'b0;
      #2 rst_n = 1'b1;
      rs = 5'd4;
      #1;
      nCompared++;
      if (readData1A !== 32'd0) begin
         nMismatched++;
         $display("FAIL reset_write_discarded: got %h want 0", readData1A);
      end
   endtask

   task automatic test_dual_write();
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd1; wd0 = 32'd9;
      we1 = 1'b1; wa1 = 5'd2; wd1 = 32'd7;
      rs = 5'd1; rt = 5'd2;
      step();
      idle();
      nCompared++;
      if (readData1A !== 32'd9 || readData2A !== 32'd7) begin
         nMismatched++;
         $display("FAIL dual_write: got %h/%h want 9/7", readData1A, readData2A);
      end
      nCompared++;
      if (conflictA !== 1'b0) begin
         nMismatched++;
         $display("FAIL dual_conflict: got %b want 0", conflictA);
      end
   endtask

   task automatic test_collision();
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11;
      we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22;
      rs = 5'd5;
      step();
      idle();
      nCompared++;
      if (readData1A !== 32'h22) begin
         nMismatched++;
         $display("FAIL collision_data: got %h want 22", readData1A);
      end
      nCompared++;
      if (conflictA !== 1'b1) begin
         nMismatched++;
         $display("FAIL collision_flag_set: got %b want 1", conflictA);
      end
      step();
      nCompared++;
      if (conflictA !== 1'b0) begin
         nMismatched++;
         $display("FAIL collision_flag_clear: got %b want 0", conflictA);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      rs = 5'd0;
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
      #1;
      nCompared++;
      if (readData1A !== 32'd0 || readData1B !== 32'd0) begin
         nMismatched++;
         $display("FAIL zero_before: got %h/%h want 0/0", readData1A, readData1B);
      end
      step();
      idle();
      nCompared++;
      if (readData1A !== 32'd0) begin
         nMismatched++;
         $display("FAIL zero_hardwired: got %h want 0", readData1A);
      end
      nCompared++;
      if (readData1B !== 32'hFFFFFFFF) begin
         nMismatched++;
         $display("FAIL zero_ordinary: got %h want ffffffff", readData1B);
      end
      @(negedge clk);
      we0 = 1'b1; we1 = 1'b1; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h5; wd1 = 32'h6;
      step();
      idle();
      nCompared++;
      if (conflictA !== 1'b1 || readData1A !== 32'd0) begin
         nMismatched++;
         $display("FAIL zero_collision: got flag=%b data=%h want 1/0", conflictA, readData1A);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] expectBefore;
`ifdef RF_WRITE_BYPASS_EN
      expectBefore = 32'd8;
`else
      expectBefore = 32'd4;
`endif
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd4;
      step();
      idle();
      @(negedge clk);
      we1 = 1'b1; wa1 = 5'd3; wd1 = 32'd8;
      rt = 5'd3;
      #1;
      nCompared++;
      if (readData2A !== expectBefore) begin
         nMismatched++;
         $display("FAIL bypass_before: got %h want %h", readData2A, expectBefore);
      end
      step();
      idle();
      nCompared++;
      if (readData2A !== 32'd8) begin
         nMismatched++;
         $display("FAIL bypass_after: got %h want 8", readData2A);
      end
      @(negedge clk);
      we0 = 1'b0; wa0 = 5'd3; wd0 = 'x;
      we1 = 1'b0; wa1 = 5'd3; wd1 = 32'hBAD;
      step();
      idle();
      nCompared++;
      if (readData2A !== 32'd8) begin
         nMismatched++;
         $display("FAIL we_low_no_effect: got %h want 8", readData2A);
      end
   endtask

   task automatic test_param();
      logic [15:0] expected;
      @(negedge clk);
      we0C = 1'b1; wa0C = 3'd7; wd0C = 16'hABCD;
      step();
      idle();
      for (int i = 0; i < 8; i++) begin
         rsC = 3'(i);
         rtC = 3'(7 - i);
         #1;
         expected = (i == 7) ? 16'hABCD : 16'h0000;
         nCompared++;
         if (readData1C !== expected) begin
            nMismatched++;
            $display("FAIL param_r%0d: got %h want %h", i, readData1C, expected);
         end
      end
      nCompared++;
      if (conflictC !== 1'b0) begin
         nMismatched++;
         $display("FAIL param_conflict: got %b want 0", conflictC);
      end
   endtask

   initial begin
      test_reset();
      test_dual_write();
      test_collision();
      test_zero_reg();
      test_bypass();
      test_param();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
